// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared types and defaults for the Fifo read-side controller.
// Holds the FSM state encoding and the skid-occupancy pop gate.
package fifo_pop_ctrl_pkg;

  localparam int DATA_WIDTH_DEF  = 10;
  localparam int COUNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Words buffered plus the word still in flight from the Fifo must fit the 2-entry skid.
  // Using only registered occupancy costs a bubble every third cycle at full rate.
  function automatic logic can_pop(input logic [1:0] skid_cnt, input logic inflight);
    logic [2:0] occ;
    occ = {1'b0, skid_cnt} + {2'b00, inflight};
    return occ < 3'd2;
  endfunction

endpackage

// File: rtl/fifo_pop_ctrl_skid_buffer2.sv
// Two-entry circular skid buffer: head is presented while cnt != 0.
// Zero-cycle read of the head; writes land the cycle after wr is sampled.
module skid_buffer2 #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rd_ok;

  assign rd_ok = rd & (cnt_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (rd_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({wr, rd_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Fifo read-side controller: pops the Fifo, parks words in a 2-entry skid, delivers on valid/ready.
// Pop-to-valid latency 2 cycles; pop is gated on registered skid occupancy so ready_in never reaches pop.
module fifo_pop_ctrl
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH_DEF,
  parameter int count_width = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic                   fifo_error,
  input  logic [data_width-1:0]  FIFO_data_out,
  output logic                   pop,
  output logic                   rd_enable,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [2:0]             state,
  output logic                   idle,
  output logic [count_width-1:0] word_count
);

  state_e                 state_q, state_d;
  logic                   idle_q, idle_d;
  logic                   inflight_q, inflight_d;
  logic [count_width-1:0] word_count_q, word_count_d;
  logic [1:0]             skid_cnt;
  logic                   skid_empty;
  logic                   xfer;

  assign valid_out  = (skid_cnt != 2'd0);
  assign skid_empty = ~valid_out;
  assign xfer       = valid_out & ready_in;
  assign pop        = (state_q == ST_ACTIVE) & ~fifo_empty & can_pop(skid_cnt, inflight_q);
  assign rd_enable  = pop;
  assign state      = state_q;
  assign idle       = idle_q;
  assign word_count = word_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_IDLE;
      ST_IDLE:   if (enable && !fifo_empty) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!enable) begin
          state_d = ST_DRAIN;
        end else if (fifo_empty && !inflight_q && skid_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_ACTIVE;
        end else if (!inflight_q && skid_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
    // The reset state always finishes its single cycle, even under a Fifo error.
    if (fifo_error && (state_q != ST_RESET)) begin
      state_d = ST_ERROR;
    end
    idle_d       = (state_d == ST_IDLE);
    inflight_d   = pop;
    word_count_d = word_count_q + {{(count_width-1){1'b0}}, xfer};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      idle_q       <= 1'b0;
      inflight_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      inflight_q   <= inflight_d;
      word_count_q <= word_count_d;
    end
  end

  skid_buffer2 #(
    .DW(data_width)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr      (inflight_q),
    .wr_data (FIFO_data_out),
    .rd      (xfer),
    .head    (data_out),
    .cnt     (skid_cnt)
  );

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: emulated Fifo, queue scoreboard, reset/FSM vector table,
// directed multi-cycle sequences and a randomized run.
module tb_fifo_pop_ctrl;

  localparam int DW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_error = 1'b0;
  logic          ready_in = 1'b0;
  logic [DW-1:0] FIFO_data_out = '0;
  logic          pop, rd_enable, valid_out, idle;
  logic [DW-1:0] data_out;
  logic [2:0]    state;
  logic [CW-1:0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cyc[$];
  int            delivered = 0;
  int            pop_total = 0;
  int            cyc = 0;

  logic          s_pop, s_valid, s_ready, s_reset;
  logic [DW-1:0] s_data;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_dat = '0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       err;
    logic [2:0] st;
    logic       idl;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  fifo_pop_ctrl #(
    .data_width (DW),
    .count_width(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_error   (fifo_error),
    .FIFO_data_out(FIFO_data_out),
    .pop          (pop),
    .rd_enable    (rd_enable),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .state        (state),
    .idle         (idle),
    .word_count   (word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, score against the queue model, then emulate the Fifo read.
  task automatic tick();
    logic exp_valid;
    @(negedge clk);
    s_pop   = pop;
    s_valid = valid_out;
    s_ready = ready_in;
    s_reset = reset;
    s_data  = data_out;
    exp_valid = (exp_cyc.size() != 0) && (exp_cyc[0] + 2 <= cyc);
    check("valid_latency", 32'(s_valid), 32'(exp_valid));
    check("word_count", 32'(word_count), 32'(delivered[CW-1:0]));
    check("rd_enable", 32'(rd_enable), 32'(s_pop));
    if (s_valid && exp_q.size() != 0) check("data_order", 32'(s_data), 32'(exp_q[0]));
    if (hold_pend) begin
      check("hold_valid", 32'(s_valid), 32'd1);
      check("hold_data", 32'(s_data), 32'(hold_dat));
    end
    if (s_valid && s_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(exp_cyc.pop_front());
      delivered++;
    end
    if (s_pop) begin
      check("pop_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        exp_q.push_back(fifo_q[0]);
        exp_cyc.push_back(cyc);
      end
      pop_total++;
    end
    check("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
    hold_pend = s_valid && !s_ready && !s_reset;
    hold_dat  = s_data;
    @(posedge clk);
    #1;
    cyc++;
    if (s_pop && fifo_q.size() != 0) FIFO_data_out = fifo_q.pop_front();
    if (s_reset) begin
      exp_q.delete();
      exp_cyc.delete();
      delivered = 0;
      hold_pend = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ready_in = 1'b0; fifo_error = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    pop_total = 0;
  endtask

  task automatic wait_delivered(input int target, input int max_cyc, input string name);
    int n;
    n = 0;
    while ((delivered < target || state != 3'd1) && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(delivered >= target && state == 3'd1), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, first_pop, first_val, n;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1};

    @(posedge clk);
    #1;

    // Reset / FSM table with an empty Fifo
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; fifo_error = vecs[i].err;
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].idl));
      check($sformatf("vec%0d_pop", i), 32'(pop), 32'd0);
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'd0);
      check($sformatf("vec%0d_wcount", i), 32'(word_count), 32'd0);
    end
    fifo_error = 1'b0;

    // Three words, consumer always ready
    do_reset();
    load(3, 10'h001);
    enable = 1'b1; ready_in = 1'b1;
    first_pop = -1; first_val = -1;
    for (int i = 0; i < 40 && !(delivered == 3 && state == 3'd1); i++) begin
      tick();
      if (s_pop && first_pop < 0) first_pop = cyc - 1;
      if (s_valid && first_val < 0) first_val = cyc - 1;
    end
    check("t2_latency", 32'(first_val - first_pop), 32'd2);
    check("t2_pops", 32'(pop_total), 32'd3);
    check("t2_word_count", 32'(word_count), 32'd3);
    check("t2_idle_state", 32'(state), 32'd1);

    // Consumer stalled: exactly two pops, head held
    do_reset();
    load(5, 10'h010);
    enable = 1'b1; ready_in = 1'b0;
    repeat (10) tick();
    check("t3_pops_stalled", 32'(pop_total), 32'd2);
    check("t3_valid", 32'(valid_out), 32'd1);
    check("t3_head", 32'(data_out), 32'h010);
    ready_in = 1'b1;
    wait_delivered(5, 60, "t3_done");
    check("t3_word_count", 32'(word_count), 32'd5);
    check("t3_pops", 32'(pop_total), 32'd5);

    // enable drops after two pops: drain, idle, then resume
    do_reset();
    load(6, 10'h020);
    enable = 1'b1; ready_in = 1'b1;
    n = 0;
    while (pop_total < 2 && n < 20) begin tick(); n++; end
    enable = 1'b0;
    tick();
    check("t4_drain_state", 32'(state), 32'd3);
    repeat (10) tick();
    check("t4_no_pop_drain", 32'(pop_total), 32'd2);
    check("t4_idle", 32'(state), 32'd1);
    check("t4_wc_drain", 32'(word_count), 32'd2);
    enable = 1'b1;
    wait_delivered(6, 80, "t4_done");
    check("t4_pops", 32'(pop_total), 32'd6);
    check("t4_word_count", 32'(word_count), 32'd6);

    // Error pulse while active
    do_reset();
    load(4, 10'h030);
    enable = 1'b1; ready_in = 1'b0;
    n = 0;
    while (pop_total < 1 && n < 20) begin tick(); n++; end
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0;
    check("t5_error_state", 32'(state), 32'd4);
    p0 = pop_total;
    repeat (6) tick();
    check("t5_no_pop", 32'(pop_total), 32'(p0));
    check("t5_sticky", 32'(state), 32'd4);
    ready_in = 1'b1;
    repeat (6) tick();
    check("t5_drained", 32'(word_count), 32'(p0));
    check("t5_valid_low", 32'(valid_out), 32'd0);
    reset = 1'b1;
    tick();
    check("t5_reset_state", 32'(state), 32'd0);
    reset = 1'b0;
    tick();

    // Reset right after a pop discards the in-flight word
    do_reset();
    load(3, 10'h040);
    enable = 1'b1; ready_in = 1'b1;
    n = 0;
    while (pop_total < 1 && n < 20) begin tick(); n++; end
    reset = 1'b1;
    tick();
    reset = 1'b0; enable = 1'b0;
    check("t6_valid", 32'(valid_out), 32'd0);
    check("t6_wcount", 32'(word_count), 32'd0);
    check("t6_state", 32'(state), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_stale", 32'(valid_out), 32'd0);
    end
    check("t6_idle", 32'(state), 32'd1);

    // Randomized traffic against the queue scoreboard
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0 && fifo_q.size() < 8) begin
        fifo_q.push_back(DW'($urandom));
        fifo_empty = 1'b0;
      end
      enable   = ($urandom_range(7) != 0);
      ready_in = ($urandom_range(2) != 0);
      reset    = ($urandom_range(149) == 0);
      tick();
    end
    reset = 1'b0; enable = 1'b1; ready_in = 1'b1;
    repeat (40) tick();
    check("rand_fifo_drained", 32'(fifo_q.size()), 32'd0);
    check("rand_valid_low", 32'(valid_out), 32'd0);
    check("rand_idle", 32'(state), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
